gcd_display_unit: RTL and testbench

Computes the greatest common divisor of two 8-bit unsigned operands with a subtractive Euclid datapath and FSM. Shows the result in decimal on a 4-digit multiplexed common-anode 7-segment display. This is the board-level top of the GCD activity: switches drive `xin`/`yin`, a button drives `go`, and `sal`/`an` drive the display pins.

---
 rtl/gcd_display_unit.sv | 134 +++++++++++++
 tb/tb_gcd_display_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_display_unit.sv
// Subtractive-Euclid GCD of two bytes, shown in decimal
// on a 4-digit multiplexed common-anode 7-segment display.
module gcd_display_unit #(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       go,
  input  logic [7:0] xin,
  input  logic [7:0] yin,
  output logic [6:0] sal,
  output logic [3:0] an
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] result;
  logic [REFRESH_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state  <= IDLE;
      x      <= 8'd0;
      y      <= 8'd0;
      result <= 8'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            x     <= xin;
            y     <= yin;
            state <= CALC;
          end
        end
        CALC: begin
          if (x == 8'd0) begin
            result <= y;
            state  <= DONE;
          end else if (y == 8'd0) begin
            result <= x;
            state  <= DONE;
          end else if (x == y) begin
            result <= x;
            state  <= DONE;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) cnt <= '0;
    else      cnt <= cnt + 1'b1;
  end

  logic [1:0] sel;
  logic [7:0] hun;
  logic [7:0] rem;
  logic [7:0] ten;
  logic [7:0] uni;
  logic [3:0] digit;
  logic       blank;

  assign sel = cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    hun = result / 8'd100;
    rem = result % 8'd100;
    ten = rem / 8'd10;
    uni = rem % 8'd10;
  end

  // Leading zeros blank; the leftmost digit is never used
  always_comb begin
    an    = 4'b1111;
    digit = 4'd0;
    blank = 1'b1;
    unique case (sel)
      2'd0: begin
        an    = 4'b1110;
        digit = uni[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        an    = 4'b1101;
        digit = ten[3:0];
        blank = (hun == 8'd0) &&
                (ten == 8'd0);
      end
      2'd2: begin
        an    = 4'b1011;
        digit = hun[3:0];
        blank = (hun == 8'd0);
      end
      2'd3: begin
        an    = 4'b0111;
        blank = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sal = 7'h7F;
    if (!blank) begin
      unique case (digit)
        4'd0: sal = 7'b1000000;
        4'd1: sal = 7'b1111001;
        4'd2: sal = 7'b0100100;
        4'd3: sal = 7'b0110000;
        4'd4: sal = 7'b0011001;
        4'd5: sal = 7'b0010010;
        4'd6: sal = 7'b0000010;
        4'd7: sal = 7'b1111000;
        4'd8: sal = 7'b0000000;
        4'd9: sal = 7'b0010000;
        default: sal = 7'h7F;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_display_unit.sv
// Directed bench for gcd_display_unit with a short
// refresh counter so full display scans stay cheap.
module tb_gcd_display_unit;

  localparam int RB   = 4;
  localparam int SCAN = 1 << RB;
  localparam int SLOT = SCAN / 4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       go  = 1'b0;
  logic [7:0] xin = 8'd0;
  logic [7:0] yin = 8'd0;
  logic [6:0] sal;
  logic [3:0] an;

  int total  = 0;
  int passed = 0;

  gcd_display_unit #(.REFRESH_BITS(RB)) dut (
    .clk(clk),
    .clr(clr),
    .go (go),
    .xin(xin),
    .yin(yin),
    .sal(sal),
    .an (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segpat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_gcd(
    input logic [7:0] a,
    input logic [7:0] b,
    input int         n,
    input logic [7:0] g,
    input string      name
  );
    int cyc;
    cyc = 0;
    xin = a;
    yin = b;
    go  = 1'b1;
    tick();
    go  = 1'b0;
    xin = 8'hAA;
    yin = 8'h55;
    while (dut.state !== 2'd2 && cyc < 300) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc !== n + 1)
      $display("FAIL %s latency got %0d exp %0d",
               name, cyc, n + 1);
    else passed++;
    total++;
    if (dut.result !== g)
      $display("FAIL %s result got %0d exp %0d",
               name, dut.result, g);
    else passed++;
  endtask

  task automatic check_display(
    input int    v,
    input string name
  );
    logic [6:0] got [4];
    logic [6:0] exp [4];
    int h, t, u, bad;
    bad = 0;
    for (int i = 0; i < 4; i++) got[i] = 7'h00;
    for (int i = 0; i < SCAN; i++) begin
      tick();
      case (an)
        4'b1110: got[0] = sal;
        4'b1101: got[1] = sal;
        4'b1011: got[2] = sal;
        4'b0111: got[3] = sal;
        default: bad++;
      endcase
    end
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    exp[0] = segpat(u);
    exp[1] = (h == 0 && t == 0) ? 7'h7F : segpat(t);
    exp[2] = (h == 0) ? 7'h7F : segpat(h);
    exp[3] = 7'h7F;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== exp[i])
        $display("FAIL %s slot%0d sal got %b exp %b",
                 name, i, got[i], exp[i]);
      else passed++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL %s anode bad cycles got %0d exp 0",
               name, bad);
    else passed++;
  endtask

  task automatic test_reset;
    clr = 1'b0;
    tick();
    tick();
    total++;
    if (dut.state !== 2'd0)
      $display("FAIL reset state got %0d exp 0", dut.state);
    else passed++;
    total++;
    if (dut.result !== 8'd0)
      $display("FAIL reset result got %0d exp 0", dut.result);
    else passed++;
    total++;
    if (an !== 4'b1110)
      $display("FAIL reset an got %b exp 1110", an);
    else passed++;
    total++;
    if (sal !== 7'b1000000)
      $display("FAIL reset sal got %b exp 1000000", sal);
    else passed++;
    clr = 1'b1;
  endtask

  task automatic test_x_gt_y;
    run_gcd(8'd228, 8'd52, 9, 8'd4, "x_gt_y");
    check_display(4, "disp_4");
  endtask

  task automatic test_x_eq_y;
    run_gcd(8'd52, 8'd52, 0, 8'd52, "x_eq_y");
    check_display(52, "disp_52");
  endtask

  task automatic test_x_lt_y;
    run_gcd(8'd45, 8'd139, 17, 8'd1, "x_lt_y");
    check_display(1, "disp_1");
  endtask

  task automatic test_zero;
    run_gcd(8'd0, 8'd77, 0, 8'd77, "zero_x");
    check_display(77, "disp_77");
    run_gcd(8'd77, 8'd0, 0, 8'd77, "zero_y");
    run_gcd(8'd0, 8'd0, 0, 8'd0, "zero_both");
    check_display(0, "disp_0");
  endtask

  task automatic test_extreme;
    run_gcd(8'd255, 8'd1, 254, 8'd1, "worst");
    run_gcd(8'd200, 8'd100, 1, 8'd100, "hundred");
    check_display(100, "disp_100");
  endtask

  task automatic test_reset_mid_calc;
    xin = 8'd255;
    yin = 8'd1;
    go  = 1'b1;
    tick();
    go  = 1'b0;
    repeat (40) tick();
    total++;
    if (dut.state !== 2'd1)
      $display("FAIL midcalc state got %0d exp 1", dut.state);
    else passed++;
    clr = 1'b0;
    tick();
    clr = 1'b1;
    total++;
    if (dut.state !== 2'd0 || dut.result !== 8'd0)
      $display("FAIL midrst state/result got %0d/%0d exp 0/0",
               dut.state, dut.result);
    else passed++;
    total++;
    if (an !== 4'b1110 || sal !== 7'b1000000)
      $display("FAIL midrst an/sal got %b/%b exp 1110/1000000",
               an, sal);
    else passed++;
    total++;
    if (dut.x !== 8'd0 || dut.y !== 8'd0)
      $display("FAIL midrst xy got %0d/%0d exp 0/0",
               dut.x, dut.y);
    else passed++;
    run_gcd(8'd91, 8'd35, 5, 8'd7, "after_rst");
  endtask

  task automatic test_go_held;
    int err, seen, cyc;
    err  = 0;
    seen = 0;
    cyc  = 0;
    xin  = 8'd12;
    yin  = 8'd18;
    go   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dut.state === 2'd2) begin
        seen++;
        if (dut.result !== 8'd6) err++;
      end
    end
    go = 1'b0;
    while (dut.state !== 2'd2 && cyc < 300) begin
      tick();
      cyc++;
    end
    total++;
    if (err !== 0 || seen == 0)
      $display("FAIL go_held bad/seen got %0d/%0d exp 0/>0",
               err, seen);
    else passed++;
    total++;
    if (dut.result !== 8'd6)
      $display("FAIL go_held result got %0d exp 6",
               dut.result);
    else passed++;
  endtask

  task automatic test_go_during_calc;
    int cyc;
    cyc = 0;
    xin = 8'd255;
    yin = 8'd1;
    go  = 1'b1;
    tick();
    xin = 8'd10;
    yin = 8'd4;
    go  = 1'b0;
    while (dut.state !== 2'd2 && cyc < 300) begin
      go = (cyc < 100) ? cyc[0] : 1'b0;
      tick();
      cyc++;
    end
    go = 1'b0;
    total++;
    if (cyc !== 255)
      $display("FAIL go_in_calc latency got %0d exp 255", cyc);
    else passed++;
    total++;
    if (dut.result !== 8'd1)
      $display("FAIL go_in_calc result got %0d exp 1",
               dut.result);
    else passed++;
    repeat (5) tick();
    total++;
    if (dut.state !== 2'd2 || dut.result !== 8'd1)
      $display("FAIL done_hold state/result got %0d/%0d exp 2/1",
               dut.state, dut.result);
    else passed++;
  endtask

  task automatic test_anode_walk;
    logic [3:0] walk [4];
    int err;
    walk[0] = 4'b1110;
    walk[1] = 4'b1101;
    walk[2] = 4'b1011;
    walk[3] = 4'b0111;
    err = 0;
    clr = 1'b0;
    tick();
    clr = 1'b1;
    for (int k = 0; k < 2 * SCAN; k++) begin
      if (an !== walk[(k / SLOT) % 4]) err++;
      tick();
    end
    total++;
    if (err !== 0)
      $display("FAIL anode_walk bad cycles got %0d exp 0", err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_x_gt_y();
    test_x_eq_y();
    test_x_lt_y();
    test_zero();
    test_extreme();
    test_reset_mid_calc();
    test_go_held();
    test_go_during_calc();
    test_anode_walk();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
